// File: rtl/mmcm_rst_ctrl.sv
// mmcm_rst_ctrl: MMCM reset/lock sequencer with retry, fault and staged domain reset release
module mmcm_rst_ctrl #(
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int N_DOMAINS           = 3,
  parameter int RELEASE_GAP         = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               mmcm_locked,
  input  logic                               relock_req,
  output logic                               mmcm_rst,
  output logic [N_DOMAINS-1:0]               domain_rst,
  output logic                               ready,
  output logic                               fault,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int M1 = RST_CYCLES > LOCK_STABLE_CYCLES ? RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int M2 = M1 > LOCK_TIMEOUT_CYCLES ? M1 : LOCK_TIMEOUT_CYCLES;
  localparam int M3 = M2 > RELEASE_GAP ? M2 : RELEASE_GAP;
  localparam int CW = $clog2(M3 + 1);

  typedef enum logic [2:0] {RESET_MMCM, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT} state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mmcm_rst_q, mmcm_rst_d;
  logic [N_DOMAINS-1:0]  domain_rst_q, domain_rst_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;
  logic                  lock_lost_q, lock_lost_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic                  locked_s;

  assign locked_s    = sync_q[1];
  assign mmcm_rst    = mmcm_rst_q;
  assign domain_rst  = domain_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;

  always_comb begin
    sync_d       = {sync_q[0], mmcm_locked};
    state_d      = state_q;
    cnt_d        = cnt_q;
    mmcm_rst_d   = mmcm_rst_q;
    domain_rst_d = domain_rst_q;
    ready_d      = ready_q;
    fault_d      = fault_q;
    lock_lost_d  = lock_lost_q;
    retry_d      = retry_q;
    // lock loss wins over relock_req so a coincident request still flags lock_lost
    if ((state_q == RELEASE || state_q == RUN) && (!locked_s || (state_q == RUN && relock_req))) begin
      state_d      = RESET_MMCM;
      cnt_d        = '0;
      mmcm_rst_d   = 1'b1;
      domain_rst_d = '1;
      ready_d      = 1'b0;
      retry_d      = '0;
      lock_lost_d  = lock_lost_q | !locked_s;
    end else begin
      case (state_q)
        RESET_MMCM: begin
          if (cnt_q == CW'(RST_CYCLES - 1)) begin
            state_d    = WAIT_LOCK;
            cnt_d      = '0;
            mmcm_rst_d = 1'b0;
          end else cnt_d = cnt_q + CW'(1);
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            cnt_d      = '0;
            mmcm_rst_d = 1'b1;
            if (retry_q < RW'(MAX_RETRIES)) begin
              retry_d = retry_q + RW'(1);
              state_d = RESET_MMCM;
            end else begin
              state_d = FAULT;
              fault_d = 1'b1;
            end
          end else cnt_d = cnt_q + CW'(1);
        end
        STABLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_STABLE_CYCLES)) begin
            cnt_d        = '0;
            domain_rst_d = domain_rst_q << 1;
            ready_d      = domain_rst_d == '0;
            state_d      = domain_rst_d == '0 ? RUN : RELEASE;
          end else cnt_d = cnt_q + CW'(1);
        end
        RELEASE: begin
          if (cnt_q == CW'(RELEASE_GAP - 1)) begin
            cnt_d        = '0;
            domain_rst_d = domain_rst_q << 1;
            ready_d      = domain_rst_d == '0;
            state_d      = domain_rst_d == '0 ? RUN : RELEASE;
          end else cnt_d = cnt_q + CW'(1);
        end
        RUN: ;
        FAULT: begin
          if (relock_req) begin
            state_d = RESET_MMCM;
            cnt_d   = '0;
            fault_d = 1'b0;
            retry_d = '0;
          end
        end
        default: state_d = RESET_MMCM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q       <= '0;
      state_q      <= RESET_MMCM;
      cnt_q        <= '0;
      mmcm_rst_q   <= 1'b1;
      domain_rst_q <= '1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      retry_q      <= '0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mmcm_rst_q   <= mmcm_rst_d;
      domain_rst_q <= domain_rst_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
      lock_lost_q  <= lock_lost_d;
      retry_q      <= retry_d;
    end
  end
endmodule

// File: tb/tb_mmcm_rst_ctrl.sv
// tb_mmcm_rst_ctrl: randomized scenarios against a phase/elapsed-time reference model with a per-cycle scoreboard
module tb_mmcm_rst_ctrl;
  localparam int RST = 16, LSC = 64, TO = 1000, MR = 3, N = 3, GAP = 8;
  localparam int M_RST = 0, M_WAIT = 1, M_STB = 2, M_REL = 3, M_RUN = 4, M_FLT = 5;

  typedef logic [8:0] vec_t;

  logic         clk = 1'b0, rst_n = 1'b0, mmcm_locked = 1'b0, relock_req = 1'b0;
  logic         mmcm_rst, ready, fault, lock_lost;
  logic [N-1:0] domain_rst;
  logic [1:0]   retry_count;

  vec_t q[$];
  vec_t exp_v, act_v;
  int   checks = 0, errors = 0;
  int   ph = M_RST, t = 0, retries = 0;
  bit   lost = 0, s1 = 0, s2 = 0;

  always #5 clk = ~clk;

  mmcm_rst_ctrl #(
    .RST_CYCLES(RST), .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(MR), .N_DOMAINS(N), .RELEASE_GAP(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mmcm_locked(mmcm_locked), .relock_req(relock_req),
    .mmcm_rst(mmcm_rst), .domain_rst(domain_rst), .ready(ready), .fault(fault),
    .lock_lost(lock_lost), .retry_count(retry_count)
  );

  // domain k is released once k*GAP cycles have elapsed in the release phase
  function automatic vec_t expect_vec();
    logic [N-1:0] d;
    d = '1;
    if (ph == M_REL) for (int k = 0; k < N; k++) d[k] = !(t >= k * GAP);
    if (ph == M_RUN) d = '0;
    return {ph == M_RST || ph == M_FLT, d, ph == M_RUN, ph == M_FLT, lost, 2'(retries)};
  endfunction

  task automatic model_edge(input bit r, input bit l, input bit rq);
    bit ls;
    ls = s2;
    if (!r) begin
      ph = M_RST; t = 0; retries = 0; lost = 0; s1 = 0; s2 = 0;
    end else begin
      s2 = s1;
      s1 = l;
      if ((ph == M_REL || ph == M_RUN) && (!ls || (ph == M_RUN && rq))) begin
        if (!ls) lost = 1;
        retries = 0; ph = M_RST; t = 0;
      end else begin
        case (ph)
          M_RST: begin
            t++;
            if (t == RST) begin ph = M_WAIT; t = 0; end
          end
          M_WAIT: begin
            if (ls) begin ph = M_STB; t = 0; end
            else begin
              t++;
              if (t == TO) begin
                t = 0;
                if (retries < MR) begin retries++; ph = M_RST; end
                else ph = M_FLT;
              end
            end
          end
          M_STB: begin
            if (!ls) begin ph = M_WAIT; t = 0; end
            else if (t == LSC) begin ph = M_REL; t = 0; end
            else t++;
          end
          M_REL: begin
            t++;
            if (t == (N - 1) * GAP) ph = M_RUN;
          end
          M_FLT: if (rq) begin ph = M_RST; t = 0; retries = 0; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic step(input bit r, input bit l, input bit rq);
    rst_n = r; mmcm_locked = l; relock_req = rq;
    @(posedge clk);
    model_edge(r, l, rq);
    q.push_back(expect_vec());
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit r, input bit l);
    repeat (n) step(r, l, 1'b0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_v = q.pop_front();
      act_v = {mmcm_rst, domain_rst, ready, fault, lock_lost, retry_count};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs @%0t rst/dom/ready/fault/lost/retry got %b expected %b", $time, act_v, exp_v);
      end
    end
  end

  initial begin
    run(3, 0, 1);
    run(130, 1, 1);
    step(1, 1, 1);
    run(130, 1, 1);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 1);
    run(130, 1, 1);
    run($urandom_range(1, 6), 1, 0);
    run(130, 1, 1);
    run(3, 0, 1);
    run(17 + $urandom_range(2, 60), 1, 1);
    run(3, 1, 0);
    run(150, 1, 1);
    run(3, 0, 1);
    run(82 + $urandom_range(0, 14), 1, 1);
    step(0, 1, 0);
    run(130, 1, 1);
    run(3, 0, 0);
    run(30, 1, 0);
    step(1, 0, 1);
    run(4 * (RST + TO) + 20, 1, 0);
    step(1, 0, 1);
    run(20, 1, 0);
    run(150, 1, 1);
    for (int i = 0; i < 40; i++) begin
      bit l;
      l = $urandom_range(0, 3) != 0;
      step(1, l, $urandom_range(0, 7) == 0);
      run($urandom_range(1, 120), 1, l);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
